multicycle_controller: RTL

Control unit for the multicycle RV32I core: a Moore FSM that sequences the shared memory, ALU, instruction register and register file across several cycles per instruction. It decodes `lw`, `sw`, R-type, I-type ALU, `beq` and `jal`, and drives the datapath select and strobe signals. It also drives the immediate-format select into the sign-extension unit. A retired-instruction counter is included for debug and performance visibility.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences memory, ALU, IR and register
// file across FETCH/DECODE/execute/writeback, and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_op,
    input  logic [2:0]         i_funct3,
    input  logic               i_funct7b5,
    input  logic               i_zero,
    output logic [1:0]         o_immSrc,
    output logic [1:0]         o_aluSrcA,
    output logic [1:0]         o_aluSrcB,
    output logic [1:0]         o_resultSrc,
    output logic               o_adrSrc,
    output logic [2:0]         o_aluControl,
    output logic               o_irWrite,
    output logic               o_pcWrite,
    output logic               o_regWrite,
    output logic               o_memWrite,
    output logic               o_illegalInstr,
    output logic [COUNT_W-1:0] o_instret
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]         r_state;
    logic [COUNT_W-1:0] r_instret;

    logic [3:0] w_state;
    logic [3:0] w_next_state;
    logic [1:0] w_aluop;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_illegal;
    logic       w_retire;
    logic       w_funct_ok;

    // Under reset the outputs present FETCH selects; strobes are masked below.
    assign w_state    = i_rst_n ? r_state : S_FETCH;
    assign w_funct_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                        (i_funct3 == 3'b110) || (i_funct3 == 3'b111);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + COUNT_W'(1);
            end
        end
    end

    // Next-state and Moore decode of the datapath controls.
    always_comb begin
        w_next_state = S_FETCH;
        w_aluop      = ALUOP_ADD;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        case (w_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (i_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R: begin
                        w_next_state = w_funct_ok ? S_EXECR : S_FETCH;
                        w_illegal    = !w_funct_ok;
                    end
                    OP_I: begin
                        w_next_state = w_funct_ok ? S_EXECI : S_FETCH;
                        w_illegal    = !w_funct_ok;
                    end
                    OP_JAL:  w_next_state = S_JAL;
                    OP_BEQ:  w_next_state = S_BEQ;
                    default: w_illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a  = 2'b10;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_aluop     = ALUOP_SUB;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // ALU operation; subtract on funct3=000 only for R-type (op[5]) with funct7b5.
    always_comb begin
        o_aluControl = ALU_ADD;
        case (w_aluop)
            ALUOP_SUB: o_aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_aluControl = (i_op[5] && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_aluControl = ALU_SLT;
                    3'b110:  o_aluControl = ALU_OR;
                    3'b111:  o_aluControl = ALU_AND;
                    default: o_aluControl = ALU_ADD;
                endcase
            end
            default: o_aluControl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (i_op)
            OP_SW:   o_immSrc = 2'b01;
            OP_BEQ:  o_immSrc = 2'b10;
            OP_JAL:  o_immSrc = 2'b11;
            default: o_immSrc = 2'b00;
        endcase
    end

    assign o_aluSrcA      = w_alu_src_a;
    assign o_aluSrcB      = w_alu_src_b;
    assign o_resultSrc    = w_result_src;
    assign o_adrSrc       = w_adr_src;
    assign o_irWrite      = i_rst_n & w_ir_write;
    assign o_pcWrite      = i_rst_n & (w_pc_update | (w_branch & i_zero));
    assign o_regWrite     = i_rst_n & w_reg_write;
    assign o_memWrite     = i_rst_n & w_mem_write;
    assign o_illegalInstr = i_rst_n & w_illegal;
    assign o_instret      = r_instret;

endmodule
